rf_wb_arbiter: RTL and testbench

Sole owner of the register file's single write port (write enable, write address, write data). After reset it runs a clear sequence that writes zero to every register from 1 to NREGS-1. It then arbitrates round-robin between NUM_REQ writeback requesters (ALU, load unit, CSR, …) using valid/ready handshakes. Every accepted write is registered and presented on the write port one cycle later.

---
 rtl/rf_wb_arbiter.sv | 96 +++++++++
 tb/tb_rf_wb_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Sole owner of the register-file write port: clears registers 1..NREGS-1 after reset,
// then arbitrates round-robin between writeback requesters with a one-cycle registered write.
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DW      = 32,
  parameter int AW      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_waddr,
  output logic [DW-1:0]         rf_wdata,
  output logic                  init_done,
  output logic                  drop_x0
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state;
  logic [AW-1:0] clr_idx;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] scan;
  logic [PW-1:0] gnt_idx;
  logic          gnt_found;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_data;

  // Walk the requesters starting at rr_ptr; the first valid one wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan = PW'((32'(rr_ptr) + k) % 32'(NUM_REQ));
      if (!gnt_found && req_valid[scan]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == RUN && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign gnt_addr = req_addr[gnt_idx*AW +: AW];
  assign gnt_data = req_data[gnt_idx*DW +: DW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_idx   <= AW'(1);
      rr_ptr    <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      init_done <= 1'b0;
      drop_x0   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          rf_we    <= 1'b1;
          rf_waddr <= clr_idx;
          rf_wdata <= '0;
          drop_x0  <= 1'b0;
          clr_idx  <= clr_idx + 1'b1;
          if (clr_idx == '1) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        RUN: begin
          rf_we   <= 1'b0;
          drop_x0 <= 1'b0;
          if (gnt_found) begin
            rf_waddr <= gnt_addr;
            rf_wdata <= gnt_data;
            rf_we    <= (gnt_addr != '0);
            drop_x0  <= (gnt_addr == '0);
            if (gnt_idx == PW'(NUM_REQ - 1)) rr_ptr <= '0;
            else                             rr_ptr <= gnt_idx + 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a behavioural model predicts grants and write-port
// activity per cycle; a separate monitor pops expectations whenever the write port is active.
module tb_rf_wb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int DW      = 32;
  localparam int AW      = 5;
  localparam int NREGS   = 1 << AW;

  logic                  clk;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rf_we;
  logic [AW-1:0]         rf_waddr;
  logic [DW-1:0]         rf_wdata;
  logic                  init_done;
  logic                  drop_x0;

  rf_wb_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .init_done(init_done), .drop_x0(drop_x0)
  );

  typedef struct {
    int unsigned   cyc;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            drop;
  } exp_t;

  exp_t        q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  bit          started = 0;

  // Pending transaction per requester, held until the model says it was granted.
  bit            pend  [NUM_REQ];
  logic [AW-1:0] paddr [NUM_REQ];
  logic [DW-1:0] pdata [NUM_REQ];

  // Reference model state
  bit run;
  int midx;
  int mrr;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
    end
  endtask

  function automatic int model_grant(input logic [NUM_REQ-1:0] v, input int rr);
    for (int j = 0; j < NUM_REQ; j++)
      if (v[(rr + j) % NUM_REQ]) return (rr + j) % NUM_REQ;
    return -1;
  endfunction

  // Monitor: every active write-port cycle must match the oldest expectation, on time.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        while (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_write expected at cycle %0d addr=%0h: actual=none required=write", e.cyc, e.addr);
        end
        if (rf_we === 1'b1 || drop_x0 === 1'b1) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write at cycle %0d: actual we=%0b drop=%0b addr=%0h required=idle",
                     cyc, rf_we, drop_x0, rf_waddr);
          end else begin
            e = q.pop_front();
            check("write_cycle", 64'(cyc), 64'(e.cyc));
            check("rf_we", 64'(rf_we), 64'(e.we));
            check("drop_x0", 64'(drop_x0), 64'(e.drop));
            check("rf_waddr", 64'(rf_waddr), 64'(e.addr));
            check("rf_wdata", 64'(rf_wdata), 64'(e.data));
          end
        end
      end
    end
  end

  // Stimulus + model
  initial begin
    int   dens;
    int   g;
    exp_t e;
    logic [NUM_REQ-1:0] exp_ready;

    rst_n = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 0; paddr[i] = '0; pdata[i] = '0;
    end
    // req2 waits through the whole clear sequence
    pend[2] = 1; paddr[2] = AW'(7); pdata[2] = DW'(32'h77);
    run = 0; midx = 1; mrr = 0;
    repeat (3) @(posedge clk);

    for (int n = 0; n < 520; n++) begin
      @(posedge clk);
      #2;
      started = 1;
      rst_n = (n != 300);
      dens = (n < 60) ? 0 : (n < 260) ? 50 : (n < 360) ? 100 : (n < 500) ? 30 : 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && $urandom_range(1, 100) <= dens) begin
          pend[i]  = 1;
          paddr[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, NREGS - 1));
          pdata[i] = DW'($urandom);
        end
        req_valid[i]         = pend[i];
        req_addr[i*AW +: AW] = paddr[i];
        req_data[i*DW +: DW] = pdata[i];
      end

      @(negedge clk);
      g = run ? model_grant(req_valid, mrr) : -1;
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_ready));
      check("init_done", 64'(init_done), 64'(run));

      if (!rst_n) begin
        run = 0; midx = 1; mrr = 0;
      end else if (!run) begin
        e.cyc = cyc + 1; e.we = 1; e.addr = AW'(midx); e.data = '0; e.drop = 0;
        q.push_back(e);
        if (midx == NREGS - 1) run = 1;
        midx++;
      end else if (g >= 0) begin
        e.cyc  = cyc + 1;
        e.we   = (paddr[g] != '0);
        e.addr = paddr[g];
        e.data = pdata[g];
        e.drop = (paddr[g] == '0);
        q.push_back(e);
        mrr = (g + 1) % NUM_REQ;
        pend[g] = 0;
      end
    end

    req_valid = '0;
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
